pong_frame_renderer: RTL and testbench

- Sits directly downstream of the VGA sync generator. Consumes its pixel position (xPos/yPos), blank_n and VS.
- Holds Pong game state: two paddles, the ball, the scores and the serve/score/game-over state machine.
- Game state advances once per frame. The block produces registered 8-bit RGB for the DAC every pixel clock.

---
 rtl/pong_frame_renderer.sv | 226 ++++++++++++++++++++++
 tb/tb_pong_frame_renderer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_frame_renderer.sv
// Pong game state (paddles, ball, scores, serve/score/game-over FSM) advanced once per frame,
// plus a registered one-clock-latency pixel colour path for the VGA DAC.
module pong_frame_renderer #(
  parameter int unsigned SCREEN_W    = 640,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned BALL_SPEED  = 2,
  parameter int unsigned PADDLE_W    = 8,
  parameter int unsigned PADDLE_H    = 64,
  parameter int unsigned PADDLE_STEP = 4,
  parameter int unsigned PADDLE_X_L  = 16,
  parameter int unsigned PADDLE_X_R  = 616,
  parameter int unsigned HOLD_FRAMES = 60,
  parameter int unsigned WIN_SCORE   = 9
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        blank_n,
  input  logic        VS,
  input  logic [10:0] xPos,
  input  logic [9:0]  yPos,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  input  logic        serve,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam logic [11:0] Speed   = 12'(BALL_SPEED);
  localparam logic [11:0] Size    = 12'(BALL_SIZE);
  localparam logic [11:0] ScrW    = 12'(SCREEN_W);
  localparam logic [11:0] ScrH    = 12'(SCREEN_H);
  localparam logic [11:0] PadW    = 12'(PADDLE_W);
  localparam logic [11:0] PadH    = 12'(PADDLE_H);
  localparam logic [11:0] Step    = 12'(PADDLE_STEP);
  localparam logic [11:0] PadXL   = 12'(PADDLE_X_L);
  localparam logic [11:0] PadXR   = 12'(PADDLE_X_R);
  localparam logic [11:0] PadMax  = 12'(SCREEN_H - PADDLE_H);
  localparam logic [11:0] PadInit = 12'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [11:0] CenX    = 12'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [11:0] CenY    = 12'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [11:0] NetX0   = 12'(SCREEN_W / 2 - 2);
  localparam logic [11:0] NetX1   = 12'(SCREEN_W / 2 + 1);
  localparam logic [7:0]  HoldEnd = 8'(HOLD_FRAMES - 1);
  localparam logic [3:0]  Win     = 4'(WIN_SCORE);

  typedef enum logic [1:0] {StIdle, StPlay, StScored, StGameOver} state_e;

  state_e      state_q, state_d;
  logic        vs_q, frame_tick;
  logic [10:0] ball_x_q, ball_x_d;
  logic [9:0]  ball_y_q, ball_y_d;
  logic        dx_q, dx_d, dy_q, dy_d;  // 1 = right / down
  logic [9:0]  pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  logic [3:0]  score_l_q, score_l_d, score_r_q, score_r_d;
  logic [7:0]  hold_q, hold_d;
  logic        serve_dir_q, serve_dir_d;
  logic [7:0]  pix_q, pix_d;

  logic [11:0] bx, by, pl, pr, px, py;
  logic        hit_l, hit_r, wall_l, wall_r;
  logic        ball_on, pad_on, net_on;

  function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
    logic [11:0] y12;
    y12 = {2'b00, y};
    if (up && !dn) return (y12 >= Step) ? 10'(y12 - Step) : 10'd0;
    if (dn && !up) return (y12 + Step >= PadMax) ? 10'(PadMax) : 10'(y12 + Step);
    return y;
  endfunction

  assign frame_tick = VS && !vs_q;
  assign bx = {1'b0, ball_x_q};
  assign by = {2'b00, ball_y_q};
  assign pl = {2'b00, pad_l_q};
  assign pr = {2'b00, pad_r_q};
  assign px = {1'b0, xPos};
  assign py = {2'b00, yPos};

  assign hit_l  = (bx <= PadXL + PadW + Speed) && (by + Size > pl) && (by < pl + PadH);
  assign hit_r  = (bx + Speed >= PadXR - Size) && (by + Size > pr) && (by < pr + PadH);
  assign wall_l = bx <= Speed;
  assign wall_r = bx + Speed >= ScrW - Size;

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      vs_q        <= 1'b1;
      ball_x_q    <= 11'(CenX);
      ball_y_q    <= 10'(CenY);
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      pad_l_q     <= 10'(PadInit);
      pad_r_q     <= 10'(PadInit);
      score_l_q   <= '0;
      score_r_q   <= '0;
      hold_q      <= '0;
      serve_dir_q <= 1'b1;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      vs_q        <= VS;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      pad_l_q     <= pad_l_d;
      pad_r_q     <= pad_r_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      hold_q      <= hold_d;
      serve_dir_q <= serve_dir_d;
      pix_q       <= pix_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    pad_l_d     = pad_l_q;
    pad_r_d     = pad_r_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    hold_d      = hold_q;
    serve_dir_d = serve_dir_q;
    if (frame_tick) begin
      if (state_q != StGameOver) begin
        pad_l_d = pad_next(pad_l_q, btn_l_up, btn_l_dn);
        pad_r_d = pad_next(pad_r_q, btn_r_up, btn_r_dn);
      end
      unique case (state_q)
        StIdle: begin
          ball_x_d = 11'(CenX);
          ball_y_d = 10'(CenY);
          if (serve) begin
            state_d = StPlay;
            dx_d    = serve_dir_q;
            dy_d    = 1'b1;
          end
        end
        StPlay: begin
          // Vertical and horizontal rules both look at pre-tick position and paddles.
          if (!dy_q && by <= Speed) begin
            ball_y_d = '0;
            dy_d     = 1'b1;
          end else if (dy_q && by + Size + Speed >= ScrH) begin
            ball_y_d = 10'(ScrH - Size);
            dy_d     = 1'b0;
          end else begin
            ball_y_d = dy_q ? 10'(by + Speed) : 10'(by - Speed);
          end
          if (!dx_q) begin
            if (hit_l) begin
              ball_x_d = 11'(PadXL + PadW);
              dx_d     = 1'b1;
            end else if (wall_l) begin
              score_r_d   = score_r_q + 4'd1;
              serve_dir_d = 1'b1;
              state_d     = StScored;
            end else begin
              ball_x_d = 11'(bx - Speed);
            end
          end else begin
            if (hit_r) begin
              ball_x_d = 11'(PadXR - Size);
              dx_d     = 1'b0;
            end else if (wall_r) begin
              score_l_d   = score_l_q + 4'd1;
              serve_dir_d = 1'b0;
              state_d     = StScored;
            end else begin
              ball_x_d = 11'(bx + Speed);
            end
          end
        end
        StScored: begin
          if (hold_q == HoldEnd) begin
            hold_d   = '0;
            ball_x_d = 11'(CenX);
            ball_y_d = 10'(CenY);
            state_d  = (score_l_q == Win || score_r_q == Win) ? StGameOver : StIdle;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        StGameOver: begin
          if (serve) begin
            score_l_d   = '0;
            score_r_d   = '0;
            serve_dir_d = 1'b1;
            state_d     = StIdle;
          end
        end
      endcase
    end
  end

  always_comb begin
    game_over = state_q == StGameOver;
    ball_on   = (state_q != StScored) && (px >= bx) && (px < bx + Size) &&
                (py >= by) && (py < by + Size);
    pad_on    = ((px >= PadXL) && (px < PadXL + PadW) && (py >= pl) && (py < pl + PadH)) ||
                ((px >= PadXR) && (px < PadXR + PadW) && (py >= pr) && (py < pr + PadH));
    net_on    = (px >= NetX0) && (px <= NetX1) && !yPos[3];
    if (!blank_n)              pix_d = 8'h00;
    else if (ball_on || pad_on) pix_d = 8'hFF;
    else if (net_on)           pix_d = 8'h80;
    else                       pix_d = 8'h00;
  end

  assign red     = pix_q;
  assign green   = pix_q;
  assign blue    = pix_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: pixel probes go through an expectation queue,
// game state is driven frame by frame with hand-derived ball trajectories.
module tb_pong_frame_renderer;

  localparam logic [23:0] Wh = 24'hFFFFFF;
  localparam logic [23:0] Gr = 24'h808080;
  localparam logic [23:0] Bk = 24'h000000;

  logic        vga_clk = 1'b0;
  logic        reset_n, blank_n, VS, serve;
  logic [10:0] xPos;
  logic [9:0]  yPos;
  logic        btn_l_up, btn_l_dn, btn_r_up, btn_r_dn;
  logic [7:0]  red, green, blue;
  logic [3:0]  score_l, score_r;
  logic        game_over;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       tag;
    logic [23:0] exp;
  } pix_exp_t;
  pix_exp_t sb_q[$];

  always #5 vga_clk = ~vga_clk;

  pong_frame_renderer dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .blank_n   (blank_n),
    .VS        (VS),
    .xPos      (xPos),
    .yPos      (yPos),
    .btn_l_up  (btn_l_up),
    .btn_l_dn  (btn_l_dn),
    .btn_r_up  (btn_r_up),
    .btn_r_dn  (btn_r_dn),
    .serve     (serve),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel, let it cross the output register, compare against the queued colour.
  task automatic probe(input string tag, input int x, input int y, input logic bl,
                       input logic [23:0] exp);
    pix_exp_t e;
    xPos    = 11'(x);
    yPos    = 10'(y);
    blank_n = bl;
    e.tag   = tag;
    e.exp   = exp;
    sb_q.push_back(e);
    @(negedge vga_clk);
    e = sb_q.pop_front();
    check_eq(e.tag, {8'h00, red, green, blue}, {8'h00, e.exp});
  endtask

  task automatic tick();
    VS = 1'b0;
    @(negedge vga_clk);
    VS = 1'b1;
    @(negedge vga_clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic serve_tick();
    serve = 1'b1;
    tick();
    serve = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge vga_clk);
    reset_n = 1'b1;
  endtask

  task automatic set_btns(input logic lu, input logic ld, input logic ru, input logic rd);
    btn_l_up = lu;
    btn_l_dn = ld;
    btn_r_up = ru;
    btn_r_dn = rd;
  endtask

  initial begin
    reset_n = 1'b0;
    VS      = 1'b1;
    blank_n = 1'b0;
    serve   = 1'b0;
    xPos    = '0;
    yPos    = '0;
    set_btns(0, 0, 0, 0);
    repeat (3) @(negedge vga_clk);
    check_eq("rst_rgb", {8'h00, red, green, blue}, 32'h0);
    check_eq("rst_score_l", 32'(score_l), 32'd0);
    check_eq("rst_score_r", 32'(score_r), 32'd0);
    check_eq("rst_game_over", 32'(game_over), 32'd0);
    reset_n = 1'b1;

    // Pixel priorities and half-open coverage at reset positions
    probe("ball_centre", 316, 236, 1, Wh);
    probe("blanked", 316, 236, 0, Bk);
    probe("net", 320, 3, 1, Gr);
    probe("net_gap", 320, 8, 1, Bk);
    probe("ball_last_px", 323, 243, 1, Wh);
    probe("ball_past_x", 324, 236, 1, Bk);
    probe("pad_l_top", 16, 208, 1, Wh);
    probe("pad_l_left_out", 15, 208, 1, Bk);
    probe("pad_l_bot_out", 16, 272, 1, Bk);
    probe("pad_r_corner", 623, 271, 1, Wh);
    probe("pad_r_right_out", 624, 271, 1, Bk);

    // Serve then ten frames: (316,236) + 10*(2,2)
    serve_tick();
    ticks(10);
    probe("fly_tl", 336, 256, 1, Wh);
    probe("fly_left_out", 335, 256, 1, Bk);
    probe("fly_br", 343, 263, 1, Wh);
    probe("fly_right_out", 344, 256, 1, Bk);
    probe("fly_below_out", 336, 264, 1, Bk);

    // Paddle travel and saturation from reset
    do_reset();
    set_btns(1, 0, 0, 1);
    ticks(51);
    probe("pad_l_51_above", 16, 3, 1, Bk);
    probe("pad_l_51_top", 16, 4, 1, Wh);
    probe("pad_r_51_above", 616, 411, 1, Bk);
    probe("pad_r_51_top", 616, 412, 1, Wh);
    tick();
    probe("pad_l_52_top", 16, 0, 1, Wh);
    probe("pad_r_52_above", 616, 415, 1, Bk);
    probe("pad_r_52_top", 616, 416, 1, Wh);
    ticks(8);
    probe("pad_l_sat_top", 16, 0, 1, Wh);
    probe("pad_l_sat_below", 16, 64, 1, Bk);
    probe("pad_r_sat_bot", 616, 479, 1, Wh);
    probe("pad_r_sat_above", 616, 415, 1, Bk);
    set_btns(1, 1, 1, 1);
    ticks(5);
    probe("both_l_top", 16, 0, 1, Wh);
    probe("both_l_below", 16, 64, 1, Bk);
    probe("both_r_top", 616, 416, 1, Wh);
    probe("both_r_above", 616, 415, 1, Bk);
    set_btns(0, 0, 0, 0);

    // Bounce walk with right paddle at 416: floor, right paddle, ceiling
    serve_tick();
    ticks(118);
    probe("floor_top", 552, 472, 1, Wh);
    probe("floor_above", 552, 471, 1, Bk);
    probe("floor_bot", 552, 479, 1, Wh);
    ticks(28);
    probe("rpad_bounce", 608, 416, 1, Wh);
    probe("rpad_bounce_left", 607, 416, 1, Bk);
    ticks(207);
    probe("ceil_pre", 194, 2, 1, Wh);
    probe("ceil_pre_above", 194, 1, 1, Bk);
    tick();
    probe("ceil_hit", 192, 0, 1, Wh);
    probe("ceil_hit_below", 192, 8, 1, Bk);
    tick();
    probe("ceil_after", 190, 2, 1, Wh);
    probe("ceil_after_above", 190, 1, 1, Bk);
    probe("ceil_after_bot", 190, 9, 1, Wh);
    probe("ceil_after_below", 190, 10, 1, Bk);

    // Scoring: right paddle parked at 0, left paddle at 416
    do_reset();
    set_btns(0, 1, 1, 0);
    ticks(52);
    set_btns(0, 0, 0, 0);
    serve_tick();
    ticks(157);
    check_eq("pt1_before", 32'(score_l), 32'd0);
    probe("pt1_ball_tl", 630, 394, 1, Wh);
    probe("pt1_ball_br", 637, 401, 1, Wh);
    tick();
    check_eq("pt1_score_l", 32'(score_l), 32'd1);
    check_eq("pt1_score_r", 32'(score_r), 32'd0);
    probe("pt1_hidden", 630, 392, 1, Bk);
    ticks(59);
    probe("pt1_hold_hidden", 316, 236, 1, Bk);
    tick();
    probe("pt1_recentred", 316, 236, 1, Wh);
    check_eq("pt1_game_over", 32'(game_over), 32'd0);

    // Loser-side serve goes left, bounces off the left paddle, exits right
    serve_tick();
    tick();
    probe("serve_left", 314, 238, 1, Wh);
    probe("serve_left_l_out", 313, 238, 1, Bk);
    probe("serve_left_r_out", 322, 238, 1, Bk);
    ticks(145);
    probe("lpad_bounce", 24, 416, 1, Wh);
    probe("lpad_bounce_br", 31, 423, 1, Wh);
    probe("lpad_bounce_r_out", 32, 416, 1, Bk);
    ticks(303);
    tick();
    check_eq("pt2_score_l", 32'(score_l), 32'd2);
    ticks(60);

    for (int p = 3; p <= 9; p++) begin
      serve_tick();
      ticks(449);
      check_eq($sformatf("pt%0d_before", p), 32'(score_l), 32'(p - 1));
      tick();
      check_eq($sformatf("pt%0d_score_l", p), 32'(score_l), 32'(p));
      ticks(59);
      check_eq($sformatf("pt%0d_hold_go", p), 32'(game_over), 32'd0);
      tick();
      check_eq($sformatf("pt%0d_game_over", p), 32'(game_over), (p == 9) ? 32'd1 : 32'd0);
    end
    check_eq("go_score_r", 32'(score_r), 32'd0);

    // Paddles frozen in game over
    set_btns(1, 0, 0, 1);
    ticks(3);
    set_btns(0, 0, 0, 0);
    probe("go_pad_r_top", 616, 0, 1, Wh);
    probe("go_pad_r_below", 616, 64, 1, Bk);
    probe("go_pad_l_top", 16, 416, 1, Wh);
    probe("go_pad_l_above", 16, 415, 1, Bk);
    probe("go_ball", 316, 236, 1, Wh);
    serve_tick();
    check_eq("restart_score_l", 32'(score_l), 32'd0);
    check_eq("restart_game_over", 32'(game_over), 32'd0);
    ticks(3);
    probe("restart_idle_ball", 316, 236, 1, Wh);

    // Reset in the middle of play with a nonzero score
    serve_tick();
    ticks(5);
    probe("mid_play_ball", 326, 246, 1, Wh);
    ticks(153);
    check_eq("mid_score_l", 32'(score_l), 32'd1);
    ticks(60);
    serve_tick();
    ticks(5);
    probe("mid_left_ball", 306, 246, 1, Wh);
    xPos    = 11'd306;
    yPos    = 10'd246;
    blank_n = 1'b1;
    do_reset();
    check_eq("mid_rst_rgb", {8'h00, red, green, blue}, 32'h0);
    check_eq("mid_rst_score_l", 32'(score_l), 32'd0);
    check_eq("mid_rst_game_over", 32'(game_over), 32'd0);
    probe("mid_rst_centre", 316, 236, 1, Wh);
    probe("mid_rst_old_pos", 306, 246, 1, Bk);
    probe("mid_rst_pad_l", 16, 208, 1, Wh);
    probe("mid_rst_pad_r", 616, 208, 1, Wh);
    probe("mid_rst_pad_r_above", 616, 207, 1, Bk);
    serve_tick();
    tick();
    probe("mid_rst_serve_right", 318, 238, 1, Wh);
    probe("mid_rst_serve_l_out", 317, 238, 1, Bk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
